// File: rtl/blink_tally_display.sv
// Saturating tally of blinker pulses shown as two multiplexed active-low 7-segment digits.
// Define TALLY_LZB_EN to blank a leading zero on the tens digit.
module blink_tally_display #(
  parameter int LIMIT       = 15,
  parameter int REFRESH_DIV = 100000,
  parameter int CNT_W       = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       pulse_in,
  output logic [CNT_W-1:0] total,
  output logic             done,
  output logic [6:0]       seg,
  output logic [1:0]       an
);

  localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [RW-1:0]    REF_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] LIM      = CNT_W'(LIMIT);

  typedef enum logic {ONES, TENS} scan_t;

  scan_t            state, state_next;
  logic [RW-1:0]    refresh_cnt;
  logic             scan_tick;
  logic [CNT_W-1:0] sum;
  logic [3:0]       tens, ones;
  logic [6:0]       seg_next;
  logic [1:0]       an_next;

  function automatic logic [1:0] popcount3(input logic [2:0] p);
    return {1'b0, p[0]} + {1'b0, p[1]} + {1'b0, p[2]};
  endfunction

  // Compare-subtract binary to BCD; valid for totals up to 159.
  function automatic logic [7:0] to_bcd(input logic [CNT_W-1:0] v);
    logic [7:0] r;
    logic [3:0] t;
    r = 8'(v);
    t = 4'd0;
    if (r >= 8'd80) begin r = r - 8'd80; t = t + 4'd8; end
    if (r >= 8'd40) begin r = r - 8'd40; t = t + 4'd4; end
    if (r >= 8'd20) begin r = r - 8'd20; t = t + 4'd2; end
    if (r >= 8'd10) begin r = r - 8'd10; t = t + 4'd1; end
    return {t, r[3:0]};
  endfunction

  function automatic logic [6:0] encode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  assign sum          = total + CNT_W'(popcount3(pulse_in));
  assign {tens, ones} = to_bcd(total);
  assign scan_tick    = (refresh_cnt == REF_LAST);

  // Accumulator: overshoot clamps to LIMIT and freezes with done.
  always_ff @(posedge clk) begin
    if (reset) begin
      total <= '0;
      done  <= 1'b0;
    end else if (!done) begin
      if (sum >= LIM) begin
        total <= LIM;
        done  <= 1'b1;
      end else begin
        total <= sum;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ONES;
      refresh_cnt <= '0;
      an          <= 2'b11;
      seg         <= 7'b1111111;
    end else begin
      state       <= state_next;
      refresh_cnt <= scan_tick ? '0 : refresh_cnt + 1'b1;
      an          <= an_next;
      seg         <= seg_next;
    end
  end

  always_comb begin
    state_next = state;
    if (scan_tick) state_next = (state == ONES) ? TENS : ONES;
  end

  always_comb begin
    an_next  = 2'b10;
    seg_next = encode(ones);
    if (state == TENS) begin
      an_next  = 2'b01;
`ifdef TALLY_LZB_EN
      seg_next = (tens == 4'd0) ? 7'b1111111 : encode(tens);
`else
      seg_next = encode(tens);
`endif
    end
  end

endmodule

// File: tb/tb_blink_tally_display.sv
// Randomized bench for blink_tally_display against a behavioural model of two instances
// (LIMIT 15 and LIMIT 23, REFRESH_DIV 4) sharing stimulus.
module tb_blink_tally_display;
  localparam int R  = 4;
  localparam int CW = 7;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [2:0]    pulse_in = 3'b000;
  logic [CW-1:0] total_a, total_b;
  logic          done_a, done_b;
  logic [6:0]    seg_a, seg_b;
  logic [1:0]    an_a, an_b;

  always #5 clk = ~clk;

  blink_tally_display #(.LIMIT(15), .REFRESH_DIV(R), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .pulse_in(pulse_in),
    .total(total_a), .done(done_a), .seg(seg_a), .an(an_a));

  blink_tally_display #(.LIMIT(23), .REFRESH_DIV(R), .CNT_W(CW)) dut23 (
    .clk(clk), .reset(reset), .pulse_in(pulse_in),
    .total(total_b), .done(done_b), .seg(seg_b), .an(an_b));

  int checks = 0;
  int errors = 0;

  int lim[2] = '{15, 23};
  int mt[2];
  bit md[2];
  int n;

  logic [6:0] enc_tab[10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                              7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [6:0] enc(input int d);
    return (d >= 0 && d < 10) ? enc_tab[d] : 7'b1111111;
  endfunction

  function automatic logic [8:0] disp(input int t, input int ph);
    if (ph == 0) return {2'b10, enc(t % 10)};
`ifdef TALLY_LZB_EN
    if (t / 10 == 0) return {2'b01, 7'b1111111};
`endif
    return {2'b01, enc(t / 10)};
  endfunction

  task automatic step(input logic [2:0] p, input logic r);
    logic [8:0] ed[2];
    int ph;
    pulse_in = p;
    reset    = r;
    @(posedge clk);
    ph = (n / R) % 2;
    for (int i = 0; i < 2; i++) begin
      if (r) begin
        ed[i] = 9'h1ff;
        mt[i] = 0;
        md[i] = 1'b0;
      end else begin
        ed[i] = disp(mt[i], ph);
        if (!md[i]) begin
          mt[i] = mt[i] + $countones(p);
          if (mt[i] >= lim[i]) begin
            mt[i] = lim[i];
            md[i] = 1'b1;
          end
        end
      end
    end
    n = r ? 0 : n + 1;
    #1;
    check("a_total", 32'(total_a), 32'(mt[0]));
    check("a_done",  32'(done_a),  32'(md[0]));
    check("a_an",    32'(an_a),    32'(ed[0][8:7]));
    check("a_seg",   32'(seg_a),   32'(ed[0][6:0]));
    check("b_total", 32'(total_b), 32'(mt[1]));
    check("b_done",  32'(done_b),  32'(md[1]));
    check("b_an",    32'(an_b),    32'(ed[1][8:7]));
    check("b_seg",   32'(seg_b),   32'(ed[1][6:0]));
    reset = 1'b0;
  endtask

  initial begin
    n = 0;
    // Reset release and idle scan
    step(3'b000, 1'b1);
    check("rst_an", 32'(an_a), 32'(2'b11));
    check("rst_seg", 32'(seg_a), 32'(7'b1111111));
    for (int i = 0; i < 12; i++) step(3'b000, 1'b0);

    // 12 rotating single pulses then all three
    for (int i = 0; i < 12; i++) step(3'(1 << (i % 3)), 1'b0);
    step(3'b111, 1'b0);
    check("tp15_total", 32'(total_a), 32'd15);
    check("tp15_done", 32'(done_a), 32'd1);
    for (int i = 0; i < 10; i++) step(3'b000, 1'b0);

    // Clamp from 14, then held saturation
    step(3'b000, 1'b1);
    for (int i = 0; i < 14; i++) step(3'b001, 1'b0);
    step(3'b111, 1'b0);
    check("clamp_total", 32'(total_a), 32'd15);
    for (int i = 0; i < 20; i++) step(3'b111, 1'b0);
    check("frozen_total", 32'(total_a), 32'd15);
    check("sat23_total", 32'(total_b), 32'd23);

    // LIMIT 23 reached with two-bit bursts
    step(3'b000, 1'b1);
    for (int i = 0; i < 14; i++) step(3'b011, 1'b0);
    check("b23_total", 32'(total_b), 32'd23);
    check("b23_done", 32'(done_b), 32'd1);
    for (int i = 0; i < 10; i++) step(3'b000, 1'b0);

    // Reset while showing tens of 9
    step(3'b000, 1'b1);
    for (int i = 0; i < 9; i++) step(3'b100, 1'b0);
    while ((n / R) % 2 == 0) step(3'b000, 1'b0);
    step(3'b000, 1'b0);
    step(3'b000, 1'b1);
    check("mid_rst_an", 32'(an_a), 32'(2'b11));
    step(3'b000, 1'b0);
    check("post_rst_an", 32'(an_a), 32'(2'b10));
    check("post_rst_seg", 32'(seg_a), 32'(7'b1000000));

    // Random pulses with occasional resets
    for (int k = 0; k < 4; k++) begin
      step(3'b000, 1'b1);
      for (int i = 0; i < 80; i++)
        step(3'($urandom_range(0, 7)), ($urandom_range(0, 49) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/blink_tally_display.md
Name: blink_tally_display

Overview:
- Downstream consumer of the per-LED blinker stages.
- Takes the single-cycle blink pulses from up to three blinkers and accumulates a saturating total. Asserts a stop flag at the limit so the blinkers can be gated.
- Renders the total as two decimal digits on a time-multiplexed, active-low two-digit 7-segment display.
- Replaces single-digit direct decode, which cannot show 10..15.

Parameters:
- LIMIT, 15, terminal total; accumulation stops here; legal range 1..99.
- REFRESH_DIV, 100000, clk cycles each digit is held before the scan advances; minimum 2.
- CNT_W, 7, width of the total register; must hold LIMIT+3.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- pulse_in  input  3  one-cycle blink events; bit i from blinker i
- total  output  CNT_W  current accumulated count, registered
- done  output  1  high once total == LIMIT; sticky until reset
- seg  output  7  segments, active-low; seg[0]=a .. seg[6]=g
- an  output  2  digit enables, active-low; an[0]=ones, an[1]=tens

Behaviour:
- Reset is synchronous and active-high; all state is cleared on the clk edge where reset=1. Reset values:
  - total=0, done=0
  - scan state ONES, refresh counter 0
  - an=2'b11 (all digits off), seg=7'b1111111
- Accumulation, per clock when done=0:
  - sum = total + popcount(pulse_in).
  - Simultaneous pulses are all counted: 0..3 per cycle.
  - If sum >= LIMIT: total<=LIMIT and done<=1 in the same edge. Overshoot is clamped, never wrapped.
- When done=1, pulse_in is ignored and total is frozen.
- done is registered. It rises on the same edge total reaches LIMIT; the upstream gate sees it one cycle after the final pulse.
- BCD conversion is combinational from total:
  - tens = total/10, ones = total%10.
  - Implemented by compare-subtract; no divider inference.
- Scan FSM, two states:
  - ONES -> TENS and TENS -> ONES, each transition when the refresh counter equals REFRESH_DIV-1. The counter then returns to 0.
  - The refresh counter runs continuously, independent of done.
- Display output registers, updated every clock from the current state and total (one-cycle latency):
  - ONES: an=2'b10, seg=encode(ones).
  - TENS: an=2'b01, seg=encode(tens), subject to the Optional Feature.
- encode table, active-low, matches existing display decode:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - any other value = 1111111
- A total change mid-scan is reflected on the next clock for whichever digit is active. No tearing beyond one cycle.
- Reset asserted mid-scan or mid-count:
  - state returns to the reset values on that edge;
  - the first post-reset clock drives an=2'b10 with seg=encode(0).

Optional Feature:
- Macro: TALLY_LZB_EN
- Defined: leading-zero blanking. In state TENS with tens==0, an=2'b01 and seg=1111111, so values 0..9 show as a single digit.
- Undefined: the tens digit always shows encode(tens), so total 7 displays "07".
- Ones digit behaviour is identical in both builds.

Test Plan (REFRESH_DIV=4, LIMIT=15 unless stated):
- Reset release, no pulses:
  - first clock: an=2'b10, seg=1000000;
  - after 4 clocks: an=2'b01, with seg=1111111 (LZB) or 1000000 (no LZB);
  - total=0, done=0.
- 12 single-bit pulses on rotating bits, then pulse_in=3'b111 once: 12+3=15 -> total=15, done=1 on that edge; ones digit 0010010 (5), tens digit 1111001 (1).
- total=14, then pulse_in=3'b111: clamp -> total=15, not 17; done=1.
- done=1, then 20 cycles of pulse_in=3'b111: total stays 15 and done stays 1. The scan keeps alternating an=10/01 every 4 clocks.
- Assert reset for 1 cycle while total=9 and state TENS: next edge total=0, done=0, an=2'b11, seg=1111111; the following clock an=2'b10, seg=1000000.
- LIMIT=23, drive to saturation with pulse_in=3'b011 bursts: total ends at 23; tens shows 0100100 (2), ones shows 0110000 (3); done=1.
